bus_controller: RTL and testbench

- Two-master, single-slave-bus controller for the CTI-8 system bus.
- Arbitrates between master 0 (CPU core) and master 1 (debug loader/DMA) with round-robin fairness.
- Decodes the fixed memory map into one-hot chip selects and inserts per-region wait states.
- Returns data plus a one-cycle ack/err to the granted master. It sits between the core/loader and the RAM, ROM and UART slaves.

---
 rtl/bus_controller.sv | 162 ++++++++++++++++
 tb/tb_bus_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_controller.sv
// Two-master round-robin controller for the CTI-8 bus: address decode,
// per-region wait states, and a one-cycle ack/err back to the granted master.
module bus_controller #(
    parameter int unsigned RAM_WAIT  = 0,
    parameter int unsigned ROM_WAIT  = 1,
    parameter int unsigned UART_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_req,
    input  logic [15:0] m0_addr,
    input  logic        m0_we,
    input  logic [7:0]  m0_wdata,
    output logic [7:0]  m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic [15:0] m1_addr,
    input  logic        m1_we,
    input  logic [7:0]  m1_wdata,
    output logic [7:0]  m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,

    output logic [15:0] bus_addr,
    output logic        bus_we,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [2:0]  cs
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        grant;
    logic [3:0]  wait_cnt;

    logic        any_req;
    logic        sel;
    logic [15:0] sel_addr;
    logic        sel_we;
    logic [7:0]  sel_wdata;
    logic [2:0]  cs_dec;
    logic [3:0]  wait_dec;
    logic        bad_access;

    // Contention goes to the master that was not served last.
    always_comb begin
        any_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
            sel = ~last_grant;
        end else if (m1_req) begin
            sel = 1'b1;
        end else begin
            sel = 1'b0;
        end
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_we    = sel ? m1_we    : m0_we;
        sel_wdata = sel ? m1_wdata : m0_wdata;
    end

    always_comb begin
        cs_dec   = 3'b000;
        wait_dec = 4'd0;
        if (sel_addr <= 16'h3FFF) begin
            cs_dec   = 3'b001;
            wait_dec = 4'(RAM_WAIT);
        end else if (sel_addr[15]) begin
            cs_dec   = 3'b010;
            wait_dec = 4'(ROM_WAIT);
        end else if (sel_addr[15:4] == 12'h600) begin
            cs_dec   = 3'b100;
            wait_dec = 4'(UART_WAIT);
        end
        // Unmapped holes and writes to ROM never reach a slave.
        bad_access = (cs_dec == 3'b000) || (cs_dec[1] && sel_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            wait_cnt   <= 4'd0;
            cs         <= 3'b000;
            bus_we     <= 1'b0;
            bus_addr   <= 16'h0000;
            bus_wdata  <= 8'h00;
            m0_rdata   <= 8'h00;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m1_rdata   <= 8'h00;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= sel;
                        last_grant <= sel;
                        bus_addr   <= sel_addr;
                        bus_wdata  <= sel_wdata;
                        if (bad_access) begin
                            state  <= DONE;
                            cs     <= 3'b000;
                            bus_we <= 1'b0;
                            if (sel) begin
                                m1_ack <= 1'b1;
                                m1_err <= 1'b1;
                            end else begin
                                m0_ack <= 1'b1;
                                m0_err <= 1'b1;
                            end
                        end else begin
                            state    <= ACCESS;
                            cs       <= cs_dec;
                            bus_we   <= sel_we;
                            wait_cnt <= wait_dec;
                        end
                    end
                end

                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        state  <= DONE;
                        cs     <= 3'b000;
                        bus_we <= 1'b0;
                        if (grant) begin
                            m1_rdata <= bus_rdata;
                            m1_ack   <= 1'b1;
                        end else begin
                            m0_rdata <= bus_rdata;
                            m0_ack   <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state  <= IDLE;
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller: reset abort, a decode/latency vector
// table, and round-robin alternation under continuous contention.
module tb_bus_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [7:0]  m0_wdata, m1_wdata, bus_rdata;
    logic [7:0]  m0_rdata, m1_rdata, bus_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err, bus_we;
    logic [15:0] bus_addr;
    logic [2:0]  cs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_controller #(
        .RAM_WAIT (0),
        .ROM_WAIT (1),
        .UART_WAIT(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_addr  (m0_addr),
        .m0_we    (m0_we),
        .m0_wdata (m0_wdata),
        .m0_rdata (m0_rdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_addr  (m1_addr),
        .m1_we    (m1_we),
        .m1_wdata (m1_wdata),
        .m1_rdata (m1_rdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .bus_addr (bus_addr),
        .bus_we   (bus_we),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .cs       (cs)
    );

    typedef struct {
        logic        mst;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [2:0]  exp_cs;
        logic        exp_err;
        int          exp_w;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_master(input logic mst, input logic req, input logic [15:0] addr,
                              input logic we, input logic [7:0] wdata);
        if (mst) begin
            m1_req = req; m1_addr = addr; m1_we = we; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_addr = addr; m0_we = we; m0_wdata = wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          cs_cycles;
        int          ack_cycle;
        logic        cs_bad, we_bad, other_ack, got_err;
        logic [7:0]  got_rdata, got_wdata;
        logic [15:0] got_addr;
        cs_cycles = 0; ack_cycle = 0;
        cs_bad = 0; we_bad = 0; other_ack = 0; got_err = 0; got_rdata = 8'h00;
        set_master(v.mst, 1'b1, v.addr, v.we, v.wdata);
        bus_rdata = v.rdata;
        @(posedge clk); #1;
        got_addr  = bus_addr;
        got_wdata = bus_wdata;
        // Scramble the master's inputs: the transaction must use latched values.
        set_master(v.mst, 1'b1, ~v.addr, ~v.we, ~v.wdata);
        for (int c = 1; c <= 40; c++) begin
            if (cs != 3'b000) begin
                cs_cycles++;
                if (cs !== v.exp_cs) cs_bad = 1'b1;
                if (bus_we !== v.we) we_bad = 1'b1;
            end else if (bus_we) begin
                we_bad = 1'b1;
            end
            if (v.mst ? m0_ack : m1_ack) other_ack = 1'b1;
            if (v.mst ? m1_ack : m0_ack) begin
                ack_cycle = c;
                got_err   = v.mst ? m1_err : m0_err;
                got_rdata = v.mst ? m1_rdata : m0_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        set_master(v.mst, 1'b0, v.addr, v.we, v.wdata);
        check($sformatf("v%0d_ack_latency", idx), ack_cycle, v.exp_err ? 1 : v.exp_w + 2);
        check($sformatf("v%0d_cs_cycles", idx), cs_cycles, v.exp_err ? 0 : v.exp_w + 1);
        check($sformatf("v%0d_cs_value", idx), cs_bad, 0);
        check($sformatf("v%0d_bus_we", idx), we_bad, 0);
        check($sformatf("v%0d_bus_addr", idx), got_addr, v.addr);
        check($sformatf("v%0d_bus_wdata", idx), got_wdata, v.wdata);
        check($sformatf("v%0d_err", idx), got_err, v.exp_err);
        check($sformatf("v%0d_other_ack", idx), other_ack, 0);
        if (!v.exp_err && !v.we)
            check($sformatf("v%0d_rdata", idx), got_rdata, v.rdata);
        @(posedge clk); #1;
        check($sformatf("v%0d_ack_drop", idx), {m0_ack, m1_ack}, 2'b00);
        $display("[TB] vec %0d: m%0d %s $%04h -> cs_cycles=%0d ack@%0d err=%0d rdata=%02h",
                 idx, v.mst, v.we ? "wr" : "rd", v.addr, cs_cycles, ack_cycle, got_err, got_rdata);
    endtask

    initial begin
        int   ack_seen;
        int   csn;
        int   order[$];
        logic [2:0] cs_or;

        vecs[0]  = '{1'b0, 16'h3FFF, 1'b0, 8'h00, 8'hA5, 3'b001, 1'b0, 0};
        vecs[1]  = '{1'b1, 16'h6000, 1'b1, 8'h5A, 8'h00, 3'b100, 1'b0, 2};
        vecs[2]  = '{1'b0, 16'h8000, 1'b1, 8'h33, 8'h00, 3'b000, 1'b1, 0};
        vecs[3]  = '{1'b0, 16'h4000, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 0};
        vecs[4]  = '{1'b0, 16'h5FFF, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 0};
        vecs[5]  = '{1'b1, 16'h600F, 1'b0, 8'h00, 8'h3C, 3'b100, 1'b0, 2};
        vecs[6]  = '{1'b0, 16'h6010, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 0};
        vecs[7]  = '{1'b1, 16'h7FFF, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1, 0};
        vecs[8]  = '{1'b1, 16'hFFFF, 1'b0, 8'h00, 8'hC3, 3'b010, 1'b0, 1};
        vecs[9]  = '{1'b0, 16'h8000, 1'b0, 8'h00, 8'h81, 3'b010, 1'b0, 1};
        vecs[10] = '{1'b1, 16'h0000, 1'b1, 8'h77, 8'h00, 3'b001, 1'b0, 0};
        vecs[11] = '{1'b0, 16'h6000, 1'b0, 8'h00, 8'h11, 3'b100, 1'b0, 2};

        rst_n = 1'b1;
        set_master(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
        set_master(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
        bus_rdata = 8'h00;
        #2 rst_n = 1'b0;
        #1 set_master(1'b0, 1'b1, 16'h8000, 1'b0, 8'h00);
        bus_rdata = 8'h9E;
        @(posedge clk); #1;
        check("rst_cs", cs, 3'b000);
        check("rst_acks", {m0_ack, m0_err, m1_ack, m1_err, bus_we}, 5'b0);
        check("rst_bus", {bus_addr, bus_wdata, m0_rdata, m1_rdata}, 40'h0);

        // Grant, then abort mid-ACCESS with an asynchronous reset.
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("pre_abort_cs", cs, 3'b010);
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_cs", cs, 3'b000);
        check("abort_async_bus", {bus_addr, m0_ack}, 17'h0);
        ack_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (m0_ack || m1_ack) ack_seen = 1;
        end
        check("abort_no_ack", ack_seen, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("regrant_cs", cs, 3'b010);
        check("regrant_addr", bus_addr, 16'h8000);
        ack_seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (m0_ack) begin ack_seen = c; break; end
            @(posedge clk); #1;
        end
        check("regrant_ack_latency", ack_seen, 2);
        check("regrant_rdata", m0_rdata, 8'h9E);
        set_master(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
        @(posedge clk); #1;
        $display("[TB] reset abort: m0 regranted, ack after %0d cycles", ack_seen);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Continuous contention after a fresh reset: m0 first, then strict alternation.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        set_master(1'b0, 1'b1, 16'h0010, 1'b0, 8'h00);
        set_master(1'b1, 1'b1, 16'h8010, 1'b0, 8'h00);
        bus_rdata = 8'h42;
        csn = 0;
        cs_or = 3'b000;
        for (int c = 0; c < 100 && order.size() < 4; c++) begin
            @(posedge clk); #1;
            if (cs != 3'b000) csn++;
            cs_or = cs_or | cs;
            if (m0_ack || m1_ack) begin
                order.push_back(m1_ack ? 1 : 0);
                check($sformatf("rr_cs_len_%0d", order.size()), csn, m1_ack ? 2 : 1);
                check($sformatf("rr_cs_sel_%0d", order.size()), cs_or, m1_ack ? 3'b010 : 3'b001);
                $display("[TB] rr txn %0d: granted m%0d, cs cycles=%0d", order.size(), m1_ack ? 1 : 0, csn);
                csn = 0;
                cs_or = 3'b000;
            end
        end
        set_master(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
        set_master(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00);
        check("rr_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++)
            check($sformatf("rr_order_%0d", i), order[i], i % 2);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
